// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for a classic 5-stage in-order pipeline.
//   - Detects load-use hazards between ID and a load in EX and inserts one
//     bubble by holding PC/IF-ID and flushing ID-EX.
//   - Flushes IF-ID and ID-EX on a taken branch/jump resolved in EX.
//   - Freezes the front of the pipe for MD_LATENCY cycles per mul/div.
//   - Selects EX operand forwarding from EX/MEM (2'b10) or MEM/WB (2'b01).
// Ports:
//   clk_i, rst_ni                    clock, async active-low reset
//   id_rs1_i/id_rs2_i, id_use_*_i    decode-stage sources and their use flags
//   ex_rs1_i/ex_rs2_i/ex_rd_i        EX-stage sources and destination
//   ex_mem_read_i, ex_md_start_i     EX holds a load / first cycle of mul/div
//   ex_branch_taken_i                branch/jump taken in EX
//   mem_rd_i/wb_rd_i, *_reg_write_i  later-stage destinations and write enables
//   stall_*_o, flush_*_o             pipeline register hold / bubble controls
//   fwd_a_o, fwd_b_o                 EX operand source selects
//   md_busy_o                        mul/div sequencing active
module pipeline_hazard_ctrl #(
  parameter int unsigned MD_LATENCY = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  input  logic [4:0] ex_rs1_i,
  input  logic [4:0] ex_rs2_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_mem_read_i,
  input  logic       ex_md_start_i,
  input  logic       ex_branch_taken_i,
  input  logic [4:0] mem_rd_i,
  input  logic [4:0] wb_rd_i,
  input  logic       mem_reg_write_i,
  input  logic       wb_reg_write_i,
  output logic       stall_if_o,
  output logic       stall_id_o,
  output logic       stall_ex_o,
  output logic       flush_id_o,
  output logic       flush_ex_o,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o,
  output logic       md_busy_o
);

  localparam logic [0:0] S_RUN     = 1'b0;
  localparam logic [0:0] S_MD_BUSY = 1'b1;

  // The start cycle itself is one stalled cycle and the counter expires at
  // zero, so loading LATENCY-2 yields exactly LATENCY stalled cycles.
  localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 2);

  logic [0:0] state_q, state_d;
  logic [3:0] md_cnt_q, md_cnt_d;
  logic       load_use;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] m_rd, input logic m_we,
                                         input logic [4:0] w_rd, input logic w_we);
    if (m_we && (m_rd != '0) && (m_rd == rs))      return 2'b10;
    else if (w_we && (w_rd != '0) && (w_rd == rs)) return 2'b01;
    else                                           return 2'b00;
  endfunction

  assign load_use = ex_mem_read_i && (ex_rd_i != '0) &&
                    ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                     (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

  always_comb begin
    state_d    = state_q;
    md_cnt_d   = md_cnt_q;
    stall_if_o = 1'b0;
    stall_id_o = 1'b0;
    stall_ex_o = 1'b0;
    flush_id_o = 1'b0;
    flush_ex_o = 1'b0;
    md_busy_o  = 1'b0;
    fwd_a_o    = 2'b00;
    fwd_b_o    = 2'b00;

    // Outputs are gated by reset so the pipe sees no controls during reset.
    if (rst_ni) begin
      fwd_a_o = fwd_sel(ex_rs1_i, mem_rd_i, mem_reg_write_i, wb_rd_i, wb_reg_write_i);
      fwd_b_o = fwd_sel(ex_rs2_i, mem_rd_i, mem_reg_write_i, wb_rd_i, wb_reg_write_i);

      if (state_q == S_MD_BUSY) begin
        stall_if_o = 1'b1;
        stall_id_o = 1'b1;
        stall_ex_o = 1'b1;
        md_busy_o  = 1'b1;
        if (md_cnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          md_cnt_d = md_cnt_q - 4'd1;
        end
      end else if (ex_md_start_i) begin
        stall_if_o = 1'b1;
        stall_id_o = 1'b1;
        stall_ex_o = 1'b1;
        md_busy_o  = 1'b1;
        state_d    = S_MD_BUSY;
        md_cnt_d   = MD_LOAD;
      end else if (ex_branch_taken_i) begin
        flush_id_o = 1'b1;
        flush_ex_o = 1'b1;
      end else if (load_use) begin
        stall_if_o = 1'b1;
        stall_id_o = 1'b1;
        flush_ex_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int unsigned MD_LATENCY = 4;

  typedef struct packed {
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       use1;
    logic       use2;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic [4:0] ex_rd;
    logic       mem_read;
    logic       md_start;
    logic       br;
    logic [4:0] mem_rd;
    logic [4:0] wb_rd;
    logic       mem_w;
    logic       wb_w;
    logic       rst_n;
  } stim_t;

  // Output bundle: {stall_if, stall_id, stall_ex, flush_id, flush_ex, md_busy, fwd_a, fwd_b}
  localparam logic [9:0] O_NONE = 10'b0000000000;
  localparam logic [9:0] O_LU   = 10'b1100100000;
  localparam logic [9:0] O_MD   = 10'b1110010000;
  localparam logic [9:0] O_BR   = 10'b0001100000;

  logic       clk;
  stim_t      s;
  logic       stall_if, stall_id, stall_ex, flush_id, flush_ex, md_busy;
  logic [1:0] fwd_a, fwd_b;
  logic [9:0] got;

  int unsigned n_vec;
  int unsigned n_err;
  int          busy_left;  // bench view: remaining MD_BUSY cycles after the start cycle
  logic [9:0]  exp_q[$];
  string       tag_q[$];

  pipeline_hazard_ctrl #(.MD_LATENCY(MD_LATENCY)) dut (
    .clk_i            (clk),
    .rst_ni           (s.rst_n),
    .id_rs1_i         (s.id_rs1),
    .id_rs2_i         (s.id_rs2),
    .id_use_rs1_i     (s.use1),
    .id_use_rs2_i     (s.use2),
    .ex_rs1_i         (s.ex_rs1),
    .ex_rs2_i         (s.ex_rs2),
    .ex_rd_i          (s.ex_rd),
    .ex_mem_read_i    (s.mem_read),
    .ex_md_start_i    (s.md_start),
    .ex_branch_taken_i(s.br),
    .mem_rd_i         (s.mem_rd),
    .wb_rd_i          (s.wb_rd),
    .mem_reg_write_i  (s.mem_w),
    .wb_reg_write_i   (s.wb_w),
    .stall_if_o       (stall_if),
    .stall_id_o       (stall_id),
    .stall_ex_o       (stall_ex),
    .flush_id_o       (flush_id),
    .flush_ex_o       (flush_ex),
    .fwd_a_o          (fwd_a),
    .fwd_b_o          (fwd_b),
    .md_busy_o        (md_busy)
  );

  assign got = {stall_if, stall_id, stall_ex, flush_id, flush_ex, md_busy, fwd_a, fwd_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (time %0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input stim_t v);
    if (rs == 5'd0)                          return 2'b00;
    if (v.mem_w && v.mem_rd == rs)           return 2'b10;
    if (v.wb_w && v.wb_rd == rs)             return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [9:0] ref_out(input stim_t v, input int left);
    logic [9:0] o;
    logic       lu;
    if (!v.rst_n) return O_NONE;
    lu = v.mem_read && v.ex_rd != 5'd0 &&
         ((v.use1 && v.id_rs1 == v.ex_rd) || (v.use2 && v.id_rs2 == v.ex_rd));
    if (left > 0 || v.md_start) o = O_MD;
    else if (v.br)              o = O_BR;
    else if (lu)                o = O_LU;
    else                        o = O_NONE;
    o[3:2] = ref_fwd(v.ex_rs1, v);
    o[1:0] = ref_fwd(v.ex_rs2, v);
    return o;
  endfunction

  function automatic stim_t idle();
    stim_t v;
    v = '0;
    v.rst_n = 1'b1;
    return v;
  endfunction

  // One cycle: advance bench state on the clock edge, drive new inputs just
  // after it, queue the expectation, and compare on the falling edge.
  task automatic apply(input stim_t n, input logic [9:0] exp, input bit use_ref, input string tag);
    @(posedge clk);
    if (s.rst_n) begin
      if (busy_left > 0)    busy_left--;
      else if (s.md_start)  busy_left = int'(MD_LATENCY) - 1;
    end
    #1;
    s = n;
    if (!n.rst_n) busy_left = 0;
    exp_q.push_back(use_ref ? ref_out(n, busy_left) : exp);
    tag_q.push_back(tag);
    @(negedge clk);
    check_vec(tag_q.pop_front(), got, exp_q.pop_front());
  endtask

  initial begin
    stim_t v;
    n_vec = 0;
    n_err = 0;
    busy_left = 0;

    // Reset with hazard and forwarding inputs active: all outputs must be 0.
    v = idle();
    v.mem_read = 1'b1; v.ex_rd = 5'd5; v.id_rs1 = 5'd5; v.use1 = 1'b1;
    v.mem_rd = 5'd7; v.ex_rs1 = 5'd7; v.mem_w = 1'b1;
    v.rst_n = 1'b0;
    s = v;
    apply(v, O_NONE, 1'b0, "reset");

    v = idle(); v.mem_read = 1'b1; v.ex_rd = 5'd5; v.id_rs1 = 5'd5; v.use1 = 1'b1;
    apply(v, O_LU, 1'b0, "lu_rs1");
    apply(idle(), O_NONE, 1'b0, "lu_clear");

    v = idle(); v.mem_read = 1'b1; v.ex_rd = 5'd9; v.id_rs2 = 5'd9; v.use2 = 1'b1;
    apply(v, O_LU, 1'b0, "lu_rs2");
    v.use2 = 1'b0;
    apply(v, O_NONE, 1'b0, "lu_nouse");

    v = idle(); v.mem_read = 1'b1; v.ex_rd = 5'd0; v.id_rs1 = 5'd0; v.use1 = 1'b1;
    apply(v, O_NONE, 1'b0, "lu_x0");

    v = idle(); v.mem_read = 1'b1; v.ex_rd = 5'd5; v.id_rs1 = 5'd5; v.use1 = 1'b1; v.br = 1'b1;
    apply(v, O_BR, 1'b0, "br_prio");

    v = idle(); v.mem_rd = 5'd7; v.wb_rd = 5'd7; v.ex_rs1 = 5'd7; v.mem_w = 1'b1; v.wb_w = 1'b1;
    apply(v, 10'b0000001000, 1'b0, "fwd_mem");
    v.mem_w = 1'b0;
    apply(v, 10'b0000000100, 1'b0, "fwd_wb");
    v.mem_w = 1'b1; v.mem_rd = 5'd0; v.wb_rd = 5'd0; v.ex_rs1 = 5'd0;
    apply(v, O_NONE, 1'b0, "fwd_x0");
    v = idle(); v.ex_rs2 = 5'd3; v.wb_rd = 5'd3; v.wb_w = 1'b1; v.mem_rd = 5'd4; v.mem_w = 1'b1;
    apply(v, 10'b0000000001, 1'b0, "fwd_b_wb");

    // Mul/div: exactly MD_LATENCY stalled cycles; inputs ignored while busy.
    v = idle(); v.md_start = 1'b1;
    apply(v, O_MD, 1'b0, "md_c1");
    apply(idle(), O_MD, 1'b0, "md_c2");
    v = idle(); v.md_start = 1'b1; v.br = 1'b1;
    v.mem_read = 1'b1; v.ex_rd = 5'd5; v.id_rs1 = 5'd5; v.use1 = 1'b1;
    apply(v, O_MD, 1'b0, "md_c3_ignore");
    apply(idle(), O_MD, 1'b0, "md_c4");
    apply(idle(), O_NONE, 1'b0, "md_done");

    // Reset during the second MD_BUSY cycle aborts the sequence.
    v = idle(); v.md_start = 1'b1;
    apply(v, O_MD, 1'b0, "rmd_start");
    apply(idle(), O_MD, 1'b0, "rmd_busy1");
    v = idle(); v.rst_n = 1'b0;
    apply(v, O_NONE, 1'b0, "rmd_rst");
    apply(v, O_NONE, 1'b0, "rmd_rst_hold");
    apply(idle(), O_NONE, 1'b0, "rmd_post1");
    apply(idle(), O_NONE, 1'b0, "rmd_post2");

    // Randomised traffic with small register numbers to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      v = idle();
      v.id_rs1   = 5'($urandom_range(0, 3));
      v.id_rs2   = 5'($urandom_range(0, 3));
      v.use1     = 1'($urandom_range(0, 1));
      v.use2     = 1'($urandom_range(0, 1));
      v.ex_rs1   = 5'($urandom_range(0, 3));
      v.ex_rs2   = 5'($urandom_range(0, 3));
      v.ex_rd    = 5'($urandom_range(0, 3));
      v.mem_read = 1'($urandom_range(0, 1));
      v.mem_rd   = 5'($urandom_range(0, 3));
      v.wb_rd    = 5'($urandom_range(0, 3));
      v.mem_w    = 1'($urandom_range(0, 1));
      v.wb_w     = 1'($urandom_range(0, 1));
      v.md_start = ($urandom_range(0, 9) == 0);
      v.br       = !v.md_start && ($urandom_range(0, 4) == 0);
      v.rst_n    = ($urandom_range(0, 39) != 0);
      apply(v, O_NONE, 1'b1, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_LATENCY, default 4, meaning total EX-stage cycles of a multiply/divide op; legal range 2..15.
REQ-002 SHALL have ports, name  direction  width  meaning:
  clk_i  in  1  single clock, all state on rising edge
  rst_ni  in  1  asynchronous active-low reset
  id_rs1_i, id_rs2_i  in  5 each  decode-stage source addresses
  id_use_rs1_i, id_use_rs2_i  in  1 each  decode instruction reads that source
  ex_rs1_i, ex_rs2_i  in  5 each  EX-stage source addresses
  ex_rd_i  in  5  EX-stage destination
  ex_mem_read_i  in  1  EX instruction is a load
  ex_md_start_i  in  1  EX instruction is a mul/div, first EX cycle
  ex_branch_taken_i  in  1  branch/jump resolved taken in EX
  mem_rd_i, wb_rd_i  in  5 each  EX/MEM and MEM/WB destinations
  mem_reg_write_i, wb_reg_write_i  in  1 each  those stages write the register file
  stall_if_o, stall_id_o, stall_ex_o  out  1 each  hold PC / IF-ID / ID-EX registers
  flush_id_o, flush_ex_o  out  1 each  load bubble into IF-ID / ID-EX register
  fwd_a_o, fwd_b_o  out  2 each  EX operand source select
  md_busy_o  out  1  mul/div sequencing active

Function
REQ-003 SHALL implement FSM states RUN and MD_BUSY plus a 4-bit down-counter md_cnt.
REQ-004 In RUN, ex_md_start_i=1 SHALL transition to MD_BUSY with md_cnt loaded with MD_LATENCY-2.
REQ-005 In MD_BUSY, md_cnt SHALL decrement each cycle; when md_cnt=0 the next state SHALL be RUN.
REQ-006 stall_if_o, stall_id_o, stall_ex_o and md_busy_o SHALL be 1 in the ex_md_start_i cycle in RUN and in every MD_BUSY cycle, giving exactly MD_LATENCY stalled cycles per mul/div.
REQ-007 In MD_BUSY, ex_md_start_i, ex_branch_taken_i and the load-use condition SHALL be ignored.
REQ-008 Load-use hazard SHALL be ex_mem_read_i=1, ex_rd_i!=0, and (id_use_rs1_i with id_rs1_i==ex_rd_i, or id_use_rs2_i with id_rs2_i==ex_rd_i).
REQ-009 In RUN, a load-use hazard without branch SHALL assert stall_if_o, stall_id_o and flush_ex_o for that cycle only; no state change.
REQ-010 In RUN, ex_branch_taken_i=1 SHALL assert flush_id_o and flush_ex_o and deassert all stalls, overriding load-use in the same cycle.
REQ-011 ex_md_start_i together with ex_branch_taken_i SHALL not occur; behaviour for that combination is unspecified.
REQ-012 fwd_a_o SHALL be 2'b10 if mem_reg_write_i, mem_rd_i!=0 and mem_rd_i==ex_rs1_i; else 2'b01 if wb_reg_write_i, wb_rd_i!=0 and wb_rd_i==ex_rs1_i; else 2'b00; fwd_b_o likewise on ex_rs2_i.
REQ-013 Register x0 SHALL never cause a hazard or forward.
REQ-014 All control outputs SHALL be combinational from current state and inputs, with no added latency; FSM/counter update only on clk_i rising edge.

Reset
REQ-015 rst_ni=0 SHALL immediately force state RUN and md_cnt=0, independent of clk_i.
REQ-016 While rst_ni=0, every stall, flush and md_busy_o output SHALL be 0 and fwd_a_o/fwd_b_o SHALL be 2'b00.
REQ-017 Reset asserted mid MD_BUSY SHALL abort the sequence; first cycle after release is RUN.

Verification
REQ-018 Load-use: ex_mem_read_i=1, ex_rd_i=5, id_rs1_i=5, id_use_rs1_i=1 -> stall_if_o=stall_id_o=flush_ex_o=1 for one cycle, then 0.
REQ-019 Mul/div: MD_LATENCY=4, ex_md_start_i pulse -> stall_ex_o=1 and md_busy_o=1 for exactly 4 cycles, RUN on 5th.
REQ-020 Priority: load-use and ex_branch_taken_i together -> flush_id_o=flush_ex_o=1, stall_if_o=0.
REQ-021 Forwarding: mem_rd_i=wb_rd_i=ex_rs1_i=7, both writes 1 -> fwd_a_o=2'b10; mem_reg_write_i=0 -> 2'b01; all rd=0 -> 2'b00.
REQ-022 Reset mid-op: rst_ni low in 2nd MD_BUSY cycle -> outputs 0 at once; after release, ex_md_start_i=0 -> no stall.
